// File: rtl/bram_srm_gen_if.sv
// bram_srm_gen_if: bus bundle between the cartridge CPU side, the bram memory
// port and the MCU save handshake of the bram_srm_gen mapper.
// master: environment side (CPU bus, MCU, memory read data).
// slave : the mapper itself.
interface bram_srm_gen_if #(
    parameter int ADDR_W = 19
);
    logic [23:0]       cpu_addr;
    logic [15:0]       cpu_data;
    logic              cpu_ce_lo;
    logic              cpu_oe;
    logic              cpu_we_lo;
    logic              cpu_we_hi;
    logic              cpu_tim;
    logic              sst_act;
    logic              save_ack;
    logic              brm_oe;
    logic [15:0]       brm_do;
    logic [15:0]       mem_do;
    logic [15:0]       mem_di;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ce;
    logic              mem_oe;
    logic              mem_we_lo;
    logic              mem_we_hi;
    logic              save_req;
    logic              dirty;
    logic              led;

    modport master (
        output cpu_addr, cpu_data, cpu_ce_lo, cpu_oe, cpu_we_lo, cpu_we_hi, cpu_tim,
        output sst_act, save_ack, mem_do,
        input  brm_oe, brm_do, mem_di, mem_addr, mem_ce, mem_oe, mem_we_lo, mem_we_hi,
        input  save_req, dirty, led
    );

    modport slave (
        input  cpu_addr, cpu_data, cpu_ce_lo, cpu_oe, cpu_we_lo, cpu_we_hi, cpu_tim,
        input  sst_act, save_ack, mem_do,
        output brm_oe, brm_do, mem_di, mem_addr, mem_ce, mem_oe, mem_we_lo, mem_we_hi,
        output save_req, dirty, led
    );
endinterface

// File: rtl/bram_srm_gen.sv
// bram_srm_gen: parametrised save-RAM mapper for the Mega Drive cartridge bus.
// Decodes a CPU window onto the bram port, holds a /TIME control register
// (ram enable, write protect), tracks dirty state and raises an idle-timed
// save request to the MCU once write activity has settled.
// Optional build macro: BRAM_SRM_WPROT_EN (write-protect bit implemented;
// when undefined the protect bit is forced off and cpu_data[1] is ignored).
module bram_srm_gen #(
    parameter int          ADDR_W    = 19,
    parameter logic [23:0] WIN_BASE  = 24'h200000,
    parameter int          WIN_BITS  = 20,
    parameter bit          BYTE_MODE = 1'b1,
    parameter bit          GATED     = 1'b1,
    parameter logic [23:0] IDLE_CYC  = 24'd5000000
) (
    input  logic          clk,
    input  logic          map_rst,
    bram_srm_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIRTY = 2'd1,
        ST_REQ   = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // control register
    logic        r_ram_en;
    logic        w_wprot;

    // /TIME write strobe synchroniser and edge detector
    logic        r_rw_s0;
    logic        r_rw_s1;
    logic        r_rw_d;
    logic        w_reg_wr;

    // memory write activity synchroniser and edge detector
    logic        r_wa_s0;
    logic        r_wa_s1;
    logic        r_wa_d;
    logic        w_wact;

    // decode
    logic        w_win;
    logic        w_hit;
    logic        w_we_lo;
    logic        w_we_hi;

    // flush FSM
    state_t      r_state;
    state_t      w_state_nx;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_nx;
    logic        r_pend;
    logic        w_pend_nx;
    logic        r_save_req;
    logic        w_save_req_nx;
    logic        r_dirty;
    logic        w_dirty_nx;
    logic        r_led;

    logic        w_unused;

    // ---------------- window decode (combinational bus path) ----------------
    assign w_win   = (bus.cpu_addr[23:WIN_BITS] == WIN_BASE[23:WIN_BITS]);
    assign w_hit   = !bus.cpu_ce_lo & w_win & (!GATED | r_ram_en);
    assign w_we_lo = w_hit & !bus.cpu_we_lo & !w_wprot;
    assign w_we_hi = w_hit & !bus.cpu_we_hi & !w_wprot & !BYTE_MODE;

    assign bus.mem_ce    = w_hit;
    assign bus.mem_oe    = w_hit & !bus.cpu_oe;
    assign bus.mem_addr  = bus.cpu_addr[ADDR_W:1];
    assign bus.mem_di    = bus.cpu_data;
    assign bus.mem_we_lo = w_we_lo;
    assign bus.mem_we_hi = w_we_hi;
    assign bus.brm_oe    = w_hit & !bus.cpu_oe;
    // 8-bit SRAM only drives the low lane; the upper lane floats high
    assign bus.brm_do    = BYTE_MODE ? {8'hFF, bus.mem_do[7:0]} : bus.mem_do;

    assign bus.save_req  = r_save_req;
    assign bus.dirty     = r_dirty;
    assign bus.led       = r_led;

    // bit 0 of the byte address and upper read lane are unused in some builds
    assign w_unused = ^{bus.cpu_addr[0], bus.mem_do};

    // ---------------- /TIME control register ----------------
    // register load: synchronised strobe rising edge qualified by /TIME, frozen during save-state
    assign w_reg_wr = r_rw_s1 & !r_rw_d & !bus.cpu_tim & !bus.sst_act;

    // synchronise the low-lane write strobe and keep a delayed copy for edge detection
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            r_rw_s0 <= 1'b0;
            r_rw_s1 <= 1'b0;
            r_rw_d  <= 1'b0;
        end else begin
            r_rw_s0 <= !bus.cpu_we_lo;
            r_rw_s1 <= r_rw_s0;
            r_rw_d  <= r_rw_s1;
        end
    end

    // ram enable bit of the control register
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            r_ram_en <= 1'b0;
        end else if (w_reg_wr) begin
            r_ram_en <= bus.cpu_data[0];
        end else begin
            r_ram_en <= r_ram_en;
        end
    end

`ifdef BRAM_SRM_WPROT_EN
    logic r_wprot;

    // write-protect bit of the control register
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            r_wprot <= 1'b0;
        end else if (w_reg_wr) begin
            r_wprot <= bus.cpu_data[1];
        end else begin
            r_wprot <= r_wprot;
        end
    end

    assign w_wprot = r_wprot;
`else
    assign w_wprot = 1'b0;
`endif

    // ---------------- write activity pulse ----------------
    // one pulse per bus write cycle that actually reaches the memory
    assign w_wact = r_wa_s1 & !r_wa_d;

    // synchronise the memory write strobes and keep a delayed copy for edge detection
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            r_wa_s0 <= 1'b0;
            r_wa_s1 <= 1'b0;
            r_wa_d  <= 1'b0;
        end else begin
            r_wa_s0 <= w_we_lo | w_we_hi;
            r_wa_s1 <= r_wa_s0;
            r_wa_d  <= r_wa_s1;
        end
    end

    // ---------------- flush FSM ----------------
    // flush FSM state and registered handshake outputs
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 24'd0;
            r_pend     <= 1'b0;
            r_save_req <= 1'b0;
            r_dirty    <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_pend     <= w_pend_nx;
            r_save_req <= w_save_req_nx;
            r_dirty    <= w_dirty_nx;
            r_led      <= (w_state_nx != ST_IDLE);
        end
    end

    // flush FSM next-state: idle timer after writes, then request/ack handshake
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_pend_nx     = r_pend;
        w_save_req_nx = r_save_req;
        w_dirty_nx    = r_dirty;
        case (r_state)
            ST_IDLE: begin
                if (w_wact) begin
                    w_state_nx = ST_DIRTY;
                    w_cnt_nx   = 24'd0;
                    w_dirty_nx = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_DIRTY: begin
                if (w_wact) begin
                    // fresh write restarts the idle window
                    w_cnt_nx = 24'd0;
                end else if (r_cnt == (IDLE_CYC - 24'd1)) begin
                    w_state_nx    = ST_REQ;
                    w_save_req_nx = 1'b1;
                end else if (r_cnt != 24'hFFFFFF) begin
                    w_cnt_nx = r_cnt + 24'd1;
                end else begin
                    w_cnt_nx = r_cnt;
                end
            end
            ST_REQ: begin
                w_save_req_nx = 1'b1;
                if (w_wact) begin
                    w_pend_nx = 1'b1;
                end else begin
                    w_pend_nx = r_pend;
                end
                if (bus.save_ack) begin
                    w_state_nx    = ST_WAIT;
                    w_save_req_nx = 1'b0;
                end else begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_WAIT: begin
                w_save_req_nx = 1'b0;
                if (!bus.save_ack) begin
                    if (r_pend | w_wact) begin
                        // writes during the save make the flushed image stale
                        w_pend_nx  = 1'b0;
                        w_state_nx = ST_DIRTY;
                        w_cnt_nx   = 24'd0;
                    end else begin
                        w_state_nx = ST_IDLE;
                        w_dirty_nx = 1'b0;
                    end
                end else if (w_wact) begin
                    w_pend_nx = 1'b1;
                end else begin
                    w_state_nx = ST_WAIT;
                end
            end
            default: begin
                w_state_nx    = ST_IDLE;
                w_cnt_nx      = 24'd0;
                w_pend_nx     = 1'b0;
                w_save_req_nx = 1'b0;
                w_dirty_nx    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_srm_gen.sv
// Directed testbench for bram_srm_gen (IDLE_CYC=16, other parameters default).
module tb_bram_srm_gen;

    logic clk;
    logic map_rst;
    int   total;
    int   bad;

    bram_srm_gen_if #(.ADDR_W(19)) bus ();

    bram_srm_gen #(
        .ADDR_W   (19),
        .WIN_BASE (24'h200000),
        .WIN_BITS (20),
        .BYTE_MODE(1'b1),
        .GATED    (1'b1),
        .IDLE_CYC (24'd16)
    ) dut (
        .clk    (clk),
        .map_rst(map_rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n clock edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.cpu_ce_lo = 1'b1;
        bus.cpu_oe    = 1'b1;
        bus.cpu_we_lo = 1'b1;
        bus.cpu_we_hi = 1'b1;
        bus.cpu_tim   = 1'b1;
        bus.cpu_addr  = 24'h000000;
        bus.cpu_data  = 16'h0000;
    endtask

    // /TIME register write, full strobe, then let the synchroniser settle
    task automatic reg_write(input logic [15:0] d);
        bus.cpu_data  = d;
        bus.cpu_tim   = 1'b0;
        bus.cpu_we_lo = 1'b0;
        tick(3);
        bus_idle();
        tick(3);
    endtask

    // window word write held for three edges (wact consumed on the third)
    task automatic win_write(input logic [23:0] a, input logic [15:0] d);
        bus.cpu_addr  = a;
        bus.cpu_data  = d;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_we_lo = 1'b0;
        bus.cpu_we_hi = 1'b0;
        tick(3);
        bus_idle();
    endtask

    task automatic wait_save_req();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.save_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL save_req_timeout: save_req=%b required 1 within 40 clk", bus.save_req);
        end
    endtask

    task automatic ack_cycle();
        bus.save_ack = 1'b1;
        tick(1);
        bus.save_ack = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        map_rst = 1'b1;
        tick(2);
        bus.cpu_addr  = 24'h200001;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_oe    = 1'b0;
        #1;
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL rst_save_req: got %b want 0", bus.save_req); end
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL rst_dirty: got %b want 0", bus.dirty); end
        total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL rst_led: got %b want 0", bus.led); end
        total++; if (bus.mem_ce !== 1'b0) begin bad++; $display("FAIL rst_mem_ce: got %b want 0", bus.mem_ce); end
        bus_idle();
        map_rst = 1'b0;
        tick(2);
    endtask

    task automatic test_enable();
        // read attempt before enabling: gated window stays closed
        bus.cpu_addr  = 24'h200001;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_oe    = 1'b0;
        #1;
        total++; if (bus.mem_ce !== 1'b0) begin bad++; $display("FAIL pre_en_mem_ce: got %b want 0", bus.mem_ce); end
        bus_idle();
        tick(1);
        // /TIME write of 0001; strobe released after 2 edges, /TIME and data held
        bus.cpu_data  = 16'h0001;
        bus.cpu_tim   = 1'b0;
        bus.cpu_we_lo = 1'b0;
        #1;
        total++; if (bus.mem_ce !== 1'b0) begin bad++; $display("FAIL reg_wr_mem_ce: got %b want 0", bus.mem_ce); end
        tick(2);
        bus.cpu_we_lo = 1'b1;
        bus.cpu_addr  = 24'h200001;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_oe    = 1'b0;
        bus.mem_do    = 16'h125A;
        #1;
        total++; if (bus.mem_ce !== 1'b0) begin bad++; $display("FAIL en_2clk_mem_ce: got %b want 0", bus.mem_ce); end
        tick(1);
        total++; if (bus.mem_ce !== 1'b1) begin bad++; $display("FAIL en_3clk_mem_ce: got %b want 1", bus.mem_ce); end
        total++; if (bus.mem_oe !== 1'b1) begin bad++; $display("FAIL en_3clk_mem_oe: got %b want 1", bus.mem_oe); end
        total++; if (bus.mem_addr !== 19'h0) begin bad++; $display("FAIL en_mem_addr: got %h want 0", bus.mem_addr); end
        total++; if (bus.brm_do !== 16'hFF5A) begin bad++; $display("FAIL en_brm_do: got %h want ff5a", bus.brm_do); end
        bus_idle();
        tick(3);
        // register write while save-state engine runs is ignored
        bus.sst_act = 1'b1;
        reg_write(16'h0000);
        bus.sst_act   = 1'b0;
        bus.cpu_addr  = 24'h200001;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_oe    = 1'b0;
        #1;
        total++; if (bus.mem_ce !== 1'b1) begin bad++; $display("FAIL sst_frozen_mem_ce: got %b want 1", bus.mem_ce); end
        bus_idle();
        tick(1);
    endtask

    task automatic test_flush();
        bus.cpu_addr  = 24'h200010;
        bus.cpu_data  = 16'hA55A;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_we_lo = 1'b0;
        bus.cpu_we_hi = 1'b0;
        #1;
        total++; if (bus.mem_addr !== 19'h8) begin bad++; $display("FAIL bm_mem_addr: got %h want 8", bus.mem_addr); end
        total++; if (bus.mem_we_lo !== 1'b1) begin bad++; $display("FAIL bm_we_lo: got %b want 1", bus.mem_we_lo); end
        total++; if (bus.mem_we_hi !== 1'b0) begin bad++; $display("FAIL bm_we_hi: got %b want 0", bus.mem_we_hi); end
        total++; if (bus.mem_di !== 16'hA55A) begin bad++; $display("FAIL bm_mem_di: got %h want a55a", bus.mem_di); end
        tick(2);
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL dirty_early: got %b want 0", bus.dirty); end
        tick(1);
        total++; if (bus.dirty !== 1'b1) begin bad++; $display("FAIL dirty_set: got %b want 1", bus.dirty); end
        total++; if (bus.led !== 1'b1) begin bad++; $display("FAIL led_set: got %b want 1", bus.led); end
        // readback of the byte lane
        bus.cpu_we_lo = 1'b1;
        bus.cpu_we_hi = 1'b1;
        bus.cpu_oe    = 1'b0;
        bus.mem_do    = 16'h125A;
        #1;
        total++; if (bus.brm_do !== 16'hFF5A) begin bad++; $display("FAIL bm_brm_do: got %h want ff5a", bus.brm_do); end
        total++; if (bus.brm_oe !== 1'b1) begin bad++; $display("FAIL bm_brm_oe: got %b want 1", bus.brm_oe); end
        bus_idle();
        tick(15);
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL req_15clk: got %b want 0", bus.save_req); end
        tick(1);
        total++; if (bus.save_req !== 1'b1) begin bad++; $display("FAIL req_16clk: got %b want 1", bus.save_req); end
        bus.save_ack = 1'b1;
        tick(1);
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL ack_req_drop: got %b want 0", bus.save_req); end
        total++; if (bus.dirty !== 1'b1) begin bad++; $display("FAIL ack_dirty_held: got %b want 1", bus.dirty); end
        bus.save_ack = 1'b0;
        tick(1);
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL done_dirty: got %b want 0", bus.dirty); end
        total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL done_led_idle: got %b want 0", bus.led); end
    endtask

    task automatic test_write_during_req();
        win_write(24'h200020, 16'h00C3);
        wait_save_req();
        win_write(24'h200022, 16'h003C);
        total++; if (bus.save_req !== 1'b1) begin bad++; $display("FAIL req_held_on_write: got %b want 1", bus.save_req); end
        bus.save_ack = 1'b1;
        tick(1);
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL pend_ack_req: got %b want 0", bus.save_req); end
        bus.save_ack = 1'b0;
        tick(1);
        total++; if (bus.dirty !== 1'b1) begin bad++; $display("FAIL pend_dirty: got %b want 1", bus.dirty); end
        total++; if (bus.led !== 1'b1) begin bad++; $display("FAIL pend_led: got %b want 1", bus.led); end
        tick(15);
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL pend_req_15clk: got %b want 0", bus.save_req); end
        total++; if (bus.dirty !== 1'b1) begin bad++; $display("FAIL pend_dirty_held: got %b want 1", bus.dirty); end
        tick(1);
        total++; if (bus.save_req !== 1'b1) begin bad++; $display("FAIL pend_req_16clk: got %b want 1", bus.save_req); end
        ack_cycle();
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL pend_done_dirty: got %b want 0", bus.dirty); end
    endtask

    task automatic test_wprot();
        reg_write(16'h0003);
        bus.cpu_addr  = 24'h200030;
        bus.cpu_data  = 16'h5A5A;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_we_lo = 1'b0;
        bus.cpu_we_hi = 1'b0;
        #1;
`ifdef BRAM_SRM_WPROT_EN
        total++; if (bus.mem_we_lo !== 1'b0) begin bad++; $display("FAIL wprot_we_lo: got %b want 0", bus.mem_we_lo); end
        tick(3);
        bus_idle();
        tick(3);
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL wprot_dirty: got %b want 0", bus.dirty); end
`else
        total++; if (bus.mem_we_lo !== 1'b1) begin bad++; $display("FAIL nowprot_we_lo: got %b want 1", bus.mem_we_lo); end
        tick(3);
        bus_idle();
        total++; if (bus.dirty !== 1'b1) begin bad++; $display("FAIL nowprot_dirty: got %b want 1", bus.dirty); end
        wait_save_req();
        ack_cycle();
`endif
        reg_write(16'h0001);
    endtask

    task automatic test_reset_mid_req();
        win_write(24'h200040, 16'h0011);
        wait_save_req();
        map_rst = 1'b1;
        bus.cpu_addr  = 24'h200001;
        bus.cpu_ce_lo = 1'b0;
        bus.cpu_oe    = 1'b0;
        #1;
        total++; if (bus.save_req !== 1'b0) begin bad++; $display("FAIL arst_save_req: got %b want 0", bus.save_req); end
        total++; if (bus.dirty !== 1'b0) begin bad++; $display("FAIL arst_dirty: got %b want 0", bus.dirty); end
        total++; if (bus.led !== 1'b0) begin bad++; $display("FAIL arst_led: got %b want 0", bus.led); end
        total++; if (bus.mem_ce !== 1'b0) begin bad++; $display("FAIL arst_ram_en: got %b want 0", bus.mem_ce); end
        bus_idle();
        tick(1);
        map_rst = 1'b0;
        tick(1);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        map_rst      = 1'b1;
        bus.sst_act  = 1'b0;
        bus.save_ack = 1'b0;
        bus.mem_do   = 16'h0000;
        bus_idle();
        test_reset();
        test_enable();
        test_flush();
        test_write_during_req();
        test_wprot();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
